// File: rtl/demux_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : demux_write_arbiter
//  Description : Round-robin arbiter sharing one registered 1-to-16 demux
//                write slot between four requesters, with a valid/ready
//                handshake toward the sink and a one-hot write-enable vector.
//                Optional per-destination lock scoreboard enabled by macro
//                DEMUX_WRITE_ARBITER_DEST_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_write_arbiter #(
   parameter int bits = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [3:0]      req,
   input  logic [3:0]      dest_0,
   input  logic [3:0]      dest_1,
   input  logic [3:0]      dest_2,
   input  logic [3:0]      dest_3,
   input  logic [bits-1:0] data_0,
   input  logic [bits-1:0] data_1,
   input  logic [bits-1:0] data_2,
   input  logic [bits-1:0] data_3,
   output logic [3:0]      ack,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_select,
   output logic [bits-1:0] out_data,
   output logic [15:0]     out_wen,
   // Per-destination busy clear ("release" is a reserved word)
   input  logic [15:0]     release_dest
);

   localparam int c_NUM_REQ = 4;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [1:0]      r_ptr;
   logic [3:0]      r_select;
   logic [bits-1:0] r_data;
   logic [15:0]     r_wen;

   logic [3:0]      w_dest [c_NUM_REQ];
   logic [bits-1:0] w_data [c_NUM_REQ];
   logic [3:0]      w_eligible;
   logic            w_found;
   logic [1:0]      w_winner;
   logic [1:0]      w_idx;
   logic            w_load;
   logic [3:0]      w_dest_win;
   logic [bits-1:0] w_data_win;

   assign w_dest[0] = dest_0;
   assign w_dest[1] = dest_1;
   assign w_dest[2] = dest_2;
   assign w_dest[3] = dest_3;
   assign w_data[0] = data_0;
   assign w_data[1] = data_1;
   assign w_data[2] = data_2;
   assign w_data[3] = data_3;

`ifdef DEMUX_WRITE_ARBITER_DEST_LOCK_EN
   logic [15:0] r_busy;
   logic [15:0] w_busy_set;

   // A requester whose destination is still locked is skipped, not waited on
   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < c_NUM_REQ; i++) begin
         w_eligible[i] = req[i] & ~r_busy[w_dest[i]];
      end
   end

   assign w_busy_set = w_load ? (16'b1 << w_dest_win) : 16'b0;

   // Busy scoreboard: a new lock on the load edge beats a same-edge release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~release_dest) | w_busy_set;
      end
   end
`else
   logic w_unused_release;

   assign w_eligible       = req;
   assign w_unused_release = ^release_dest;
`endif

   // Round-robin search starting at the pointer, ascending with wrap
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int k = 0; k < c_NUM_REQ; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && w_eligible[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_dest_win = w_dest[w_winner];
   assign w_data_win = w_data[w_winner];

   // Slot can take a new write when empty or when the sink drains it this cycle;
   // reset_n gating keeps ack low for the whole reset interval
   assign w_load = reset_n & w_found & ((r_state == ST_EMPTY) | out_ready);
   assign ack    = w_load ? (4'b1 << w_winner) : 4'b0;

   // Slot state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Slot next-state: fill on load, drain when the sink accepts with nothing new
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_load) begin
               w_state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready && !w_load) begin
               w_state_next = ST_EMPTY;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Slot payload and pointer: capture the winner on load, clear wen on drain
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_select <= '0;
         r_data   <= '0;
         r_wen    <= '0;
         r_ptr    <= '0;
      end else if (w_load) begin
         r_select <= w_dest_win;
         r_data   <= w_data_win;
         r_wen    <= 16'b1 << w_dest_win;
         r_ptr    <= w_winner + 2'd1;
      end else if ((r_state == ST_FULL) && out_ready) begin
         r_wen    <= '0;
      end
   end

   assign out_valid  = (r_state == ST_FULL);
   assign out_select = r_select;
   assign out_data   = r_data;
   assign out_wen    = r_wen & {16{out_valid}};

endmodule
`default_nettype wire

// File: tb/tb_demux_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_write_arbiter
//  Description : Self-checking bench for demux_write_arbiter; directed steps
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_write_arbiter;

   localparam int BITS = 16;
`ifdef DEMUX_WRITE_ARBITER_DEST_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [3:0]      req = '0;
   logic [3:0]      dest [4];
   logic [BITS-1:0] data [4];
   logic            out_ready = 1'b0;
   logic [15:0]     release_dest = '0;
   logic [3:0]      ack;
   logic            out_valid;
   logic [3:0]      out_select;
   logic [BITS-1:0] out_data;
   logic [15:0]     out_wen;

   int checks = 0;
   int failures = 0;

   // Reference model state
   bit              m_valid;
   logic [3:0]      m_sel;
   logic [BITS-1:0] m_data;
   int              m_ptr;
   bit [15:0]       m_busy;

   demux_write_arbiter #(.bits(BITS)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req          (req),
      .dest_0       (dest[0]),
      .dest_1       (dest[1]),
      .dest_2       (dest[2]),
      .dest_3       (dest[3]),
      .data_0       (data[0]),
      .data_1       (data[1]),
      .data_2       (data[2]),
      .data_3       (data[3]),
      .ack          (ack),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_select   (out_select),
      .out_data     (out_data),
      .out_wen      (out_wen),
      .release_dest (release_dest)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_sel   = '0;
      m_data  = '0;
      m_ptr   = 0;
      m_busy  = '0;
   endtask

   // Who wins this cycle, if anyone: first eligible requester from ptr upward
   task automatic model_pick(output bit ld, output int w);
      bit any;
      any = 1'b0;
      w   = 0;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (!any && req[i] && !(LOCK && m_busy[dest[i]])) begin
            any = 1'b1;
            w   = i;
         end
      end
      ld = any && (!m_valid || out_ready);
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge
   task automatic cycle(input string tag);
      bit ld;
      int w;
      @(negedge clock);
      model_pick(ld, w);
      chk({tag, ":ack"}, 32'(ack), ld ? (32'd1 << w) : 32'd0);
      chk({tag, ":valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ":wen"}, 32'(out_wen), m_valid ? (32'd1 << m_sel) : 32'd0);
      if (m_valid) begin
         chk({tag, ":sel"}, 32'(out_select), 32'(m_sel));
         chk({tag, ":data"}, 32'(out_data), 32'(m_data));
      end
      @(posedge clock);
      m_busy = m_busy & ~release_dest;
      if (ld) begin
         m_valid = 1'b1;
         m_sel   = dest[w];
         m_data  = data[w];
         m_ptr   = (w + 1) % 4;
         if (LOCK) m_busy[dest[w]] = 1'b1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         dest[i] = 4'(i);
         data[i] = 16'(i);
      end
      model_reset();

      // Reset: requests present but nothing may be acknowledged
      req = 4'b1111;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("rst:ack", 32'(ack), 32'd0);
      chk("rst:valid", 32'(out_valid), 32'd0);
      chk("rst:wen", 32'(out_wen), 32'd0);
      chk("rst:sel", 32'(out_select), 32'd0);
      chk("rst:data", 32'(out_data), 32'd0);
      reset_n = 1'b1;

      // First grant after reset goes to the only requester
      req = 4'b1000; dest[3] = 4'd9; data[3] = 16'h1234; out_ready = 1'b1;
      cycle("rst_first");
      chk("rst_first:sel", 32'(out_select), 32'd9);

      // Single write
      req = 4'b0001; dest[0] = 4'd5; data[0] = 16'hABCD;
      cycle("single");
      chk("single:valid", 32'(out_valid), 32'd1);
      chk("single:sel", 32'(out_select), 32'd5);
      chk("single:data", 32'(out_data), 32'hABCD);
      chk("single:wen", 32'(out_wen), 32'h0020);
      req = 4'b0000;
      cycle("single_drop");
      chk("single_drop:valid", 32'(out_valid), 32'd0);

      // Round-robin with all requesters active
      req = 4'b1111;
      for (int i = 0; i < 4; i++) dest[i] = 4'(i + 10);
      for (int n = 0; n < 5; n++) cycle("rr");

      // Backpressure then release
      req = 4'b0010; out_ready = 1'b0; data[1] = 16'h5A5A;
      for (int n = 0; n < 3; n++) cycle("bp");
      out_ready = 1'b1;
      cycle("bp_release");
      chk("bp_release:data", 32'(out_data), 32'h5A5A);

      // Two requesters targeting the same destination
      req = 4'b0011; dest[0] = 4'd3; dest[1] = 4'd3;
      cycle("coll");
      cycle("coll");
      release_dest = 16'hFFFF;
      req = 4'b0000;
      cycle("coll_drain");
      release_dest = '0;

      // Asynchronous reset while the slot is full
      req = 4'b0100; dest[2] = 4'd7;
      cycle("mid_load");
      req = 4'b1111;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst:valid", 32'(out_valid), 32'd0);
      chk("mid_rst:wen", 32'(out_wen), 32'd0);
      chk("mid_rst:ack", 32'(ack), 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         req = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            dest[i] = 4'($urandom);
            data[i] = 16'($urandom);
         end
         out_ready    = ($urandom_range(0, 3) != 0);
         release_dest = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
